// File: rtl/bin2bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
// Holds the FSM state encoding, the BCD digit width and a digit-count helper.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int BCD_W = 4;

    // ceil(w * log10(2)) with log10(2) ~= 0.30103; the number of decimal digits of 2^w - 1.
    function automatic int min_digits(input int w);
        return (w * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Handshake and data bundle between a requester and the binary-to-BCD converter.
// The converter sits on the slave side; the requester drives start/din as master.
interface bin2bcd_seq_if
    import bin2bcd_pkg::*;
#(
    parameter int IN_W   = 16,
    parameter int DIGITS = 5
) ();

    logic                    start;
    logic [IN_W-1:0]         din;
    logic                    busy;
    logic                    done;
    logic [BCD_W*DIGITS-1:0] bcd_out;
    logic                    neg;
    logic                    overflow;

    modport master (
        output start, din,
        input  busy, done, bcd_out, neg, overflow
    );

    modport slave (
        input  start, din,
        output busy, done, bcd_out, neg, overflow
    );

endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more,
// so that the following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  logic [BCD_W-1:0] digit_i,
    output logic [BCD_W-1:0] digit_o
);

    assign digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble) with start/busy/done handshake.
// Latency is IN_W+1 cycles from the accepted start edge regardless of the input value.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int IN_W   = 16,
    parameter int DIGITS = 5,
    parameter bit SIGNED = 1'b0
) (
    input logic          clk,
    input logic          rst_n,
    bin2bcd_seq_if.slave bus
);

    localparam int ACC_W        = BCD_W * DIGITS;
    localparam int CNT_W        = $clog2(IN_W + 1);
    localparam bit CAN_OVERFLOW = (DIGITS < min_digits(IN_W));

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [IN_W-1:0]   bin_q;
    logic [ACC_W-1:0]  acc_q;
    logic              ovfAcc_q;
    logic              sign_q;
    logic [ACC_W-1:0]  bcd_q;
    logic              neg_q;
    logic              ovf_q;
    logic              busy_q;
    logic              done_q;

    logic              dinNeg_d;
    logic [IN_W-1:0]   dinMag_d;
    logic [ACC_W-1:0]  accAdj_d;
    logic [ACC_W-1:0]  accShift_d;
    logic [IN_W-1:0]   binShift_d;
    logic              ovfBit_d;

    // The most negative input maps to 2^(IN_W-1), which still fits in IN_W unsigned bits.
    assign dinNeg_d = SIGNED && bus.din[IN_W-1];
    assign dinMag_d = dinNeg_d ? (~bus.din + IN_W'(1)) : bus.din;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_i (acc_q[g*BCD_W +: BCD_W]),
            .digit_o (accAdj_d[g*BCD_W +: BCD_W])
        );
    end

    assign accShift_d = {accAdj_d[ACC_W-2:0], bin_q[IN_W-1]};
    assign binShift_d = {bin_q[IN_W-2:0], 1'b0};
    assign ovfBit_d   = accAdj_d[ACC_W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bin_q    <= '0;
            acc_q    <= '0;
            ovfAcc_q <= 1'b0;
            sign_q   <= 1'b0;
            bcd_q    <= '0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        bin_q    <= dinMag_d;
                        sign_q   <= dinNeg_d;
                        acc_q    <= '0;
                        ovfAcc_q <= 1'b0;
                        cnt_q    <= CNT_W'(IN_W);
                        busy_q   <= 1'b1;
                        state_q  <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc_q <= accShift_d;
                    bin_q <= binShift_d;
                    if (ovfBit_d) begin
                        ovfAcc_q <= 1'b1;
                    end
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // A digit can only be lost when DIGITS is too small for IN_W bits.
                    assert (CAN_OVERFLOW || !ovfAcc_q);
                    bcd_q   <= acc_q;
                    neg_q   <= sign_q;
                    ovf_q   <= ovfAcc_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.bcd_out  = bcd_q;
    assign bus.neg      = neg_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: unsigned 5-digit, signed 5-digit and truncating 4-digit
// instances share one clock; expected results are queued at start and checked on done.
module tb_bin2bcd_seq;

    typedef struct packed {
        logic [19:0] bcd;
        logic        neg;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors     = 0;
    int   miscompares = 0;
    exp_t expU[$];
    exp_t expS[$];
    exp_t expT[$];

    always #5 clk = ~clk;

    bin2bcd_seq_if #(.IN_W(16), .DIGITS(5)) ifU ();
    bin2bcd_seq_if #(.IN_W(16), .DIGITS(5)) ifS ();
    bin2bcd_seq_if #(.IN_W(16), .DIGITS(4)) ifT ();

    bin2bcd_seq #(.IN_W(16), .DIGITS(5), .SIGNED(1'b0)) dutU (.clk(clk), .rst_n(rst_n), .bus(ifU));
    bin2bcd_seq #(.IN_W(16), .DIGITS(5), .SIGNED(1'b1)) dutS (.clk(clk), .rst_n(rst_n), .bus(ifS));
    bin2bcd_seq #(.IN_W(16), .DIGITS(4), .SIGNED(1'b0)) dutT (.clk(clk), .rst_n(rst_n), .bus(ifT));

    // Reference conversion by repeated division, independent of the shift-and-add datapath.
    function automatic exp_t model(input logic [15:0] d, input bit sgn, input int digits);
        exp_t   e;
        longint mag;
        longint lim = 1;
        e     = '0;
        e.neg = sgn & d[15];
        mag   = e.neg ? (longint'(65536) - longint'(d)) : longint'(d);
        for (int i = 0; i < digits; i++) lim = lim * 10;
        e.ovf = (mag >= lim);
        mag   = mag % lim;
        for (int i = 0; i < digits; i++) begin
            e.bcd[4*i +: 4] = 4'(mag % 10);
            mag = mag / 10;
        end
        return e;
    endfunction

    function automatic exp_t observe(input int sel);
        case (sel)
            0:       return {ifU.bcd_out, ifU.neg, ifU.overflow};
            1:       return {ifS.bcd_out, ifS.neg, ifS.overflow};
            default: return {4'h0, ifT.bcd_out, ifT.neg, ifT.overflow};
        endcase
    endfunction

    function automatic logic getDone(input int sel);
        case (sel)
            0:       return ifU.done;
            1:       return ifS.done;
            default: return ifT.done;
        endcase
    endfunction

    function automatic logic getBusy(input int sel);
        case (sel)
            0:       return ifU.busy;
            1:       return ifS.busy;
            default: return ifT.busy;
        endcase
    endfunction

    function automatic exp_t popExp(input int sel);
        exp_t e = '1;
        case (sel)
            0:       if (expU.size() > 0) e = expU.pop_front();
            1:       if (expS.size() > 0) e = expS.pop_front();
            default: if (expT.size() > 0) e = expT.pop_front();
        endcase
        return e;
    endfunction

    task automatic setIn(input int sel, input logic s, input logic [15:0] d);
        case (sel)
            0:       begin ifU.start = s; ifU.din = d; end
            1:       begin ifS.start = s; ifS.din = d; end
            default: begin ifT.start = s; ifT.din = d; end
        endcase
    endtask

    task automatic dropStart(input int sel);
        case (sel)
            0:       ifU.start = 1'b0;
            1:       ifS.start = 1'b0;
            default: ifT.start = 1'b0;
        endcase
    endtask

    // Raise start with a value and queue the result the converter is expected to report.
    task automatic applyStimulus(input int sel, input logic [15:0] d);
        setIn(sel, 1'b1, d);
        case (sel)
            0:       expU.push_back(model(d, 1'b0, 5));
            1:       expS.push_back(model(d, 1'b1, 5));
            default: expT.push_back(model(d, 1'b0, 4));
        endcase
    endtask

    // Counts negedges until done is seen; cycles stays -1 if the budget expires.
    task automatic waitDone(input int sel, input int budget, input bit pulse,
                            output int cycles, output int busyCycles);
        cycles     = -1;
        busyCycles = 0;
        for (int j = 1; j <= budget; j++) begin
            @(negedge clk);
            if (pulse && j == 1) dropStart(sel);
            if (getDone(sel)) begin
                cycles = j;
                break;
            end
            if (getBusy(sel)) busyCycles++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int s = 0; s < 3; s++) setIn(s, 1'b0, 16'h0);
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            vectors++;
            if ({observe(s), getBusy(s), getDone(s)} !== 24'h0) begin
                miscompares++;
                $display("[TB] FAIL reset dut%0d outputs got %h want 000000", s,
                         {observe(s), getBusy(s), getDone(s)});
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_unsigned_max();
        int   cyc, bsy;
        exp_t e, o;
        @(negedge clk);
        applyStimulus(0, 16'hFFFF);
        waitDone(0, 40, 1'b1, cyc, bsy);
        vectors++;
        if (cyc !== 18) begin
            miscompares++;
            $display("[TB] FAIL max_latency negedges got %0d want 18", cyc);
        end
        vectors++;
        if (bsy !== 17) begin
            miscompares++;
            $display("[TB] FAIL max_busy cycles got %0d want 17", bsy);
        end
        e = popExp(0);
        o = observe(0);
        vectors++;
        if (o !== e) begin
            miscompares++;
            $display("[TB] FAIL max_result got %h want %h", o, e);
        end
        @(negedge clk);
        vectors++;
        if ({getDone(0), getBusy(0)} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL max_done_pulse done/busy got %b want 00", {getDone(0), getBusy(0)});
        end
    endtask

    task automatic test_back_to_back();
        int   c1, c2, b, gap;
        exp_t e, o;
        @(negedge clk);
        applyStimulus(0, 16'd0);
        @(negedge clk);
        applyStimulus(0, 16'd9);
        waitDone(0, 40, 1'b0, c1, b);
        e = popExp(0);
        o = observe(0);
        vectors++;
        if (o !== e) begin
            miscompares++;
            $display("[TB] FAIL b2b_first got %h want %h", o, e);
        end
        @(negedge clk);
        vectors++;
        if (getBusy(0) !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL b2b_reaccept busy got %b want 1", getBusy(0));
        end
        dropStart(0);
        waitDone(0, 40, 1'b0, c2, b);
        gap = (c1 < 0 || c2 < 0) ? -1 : (19 + c2) - (1 + c1);
        vectors++;
        if (gap !== 18) begin
            miscompares++;
            $display("[TB] FAIL b2b_gap done spacing got %0d want 18", gap);
        end
        e = popExp(0);
        o = observe(0);
        vectors++;
        if (o !== e) begin
            miscompares++;
            $display("[TB] FAIL b2b_second got %h want %h", o, e);
        end
    endtask

    task automatic test_signed();
        logic [15:0] vals [4] = '{16'h8000, 16'hFFFF, 16'h7FFF, 16'h0000};
        int          cyc, bsy;
        exp_t        e, o;
        foreach (vals[i]) begin
            @(negedge clk);
            applyStimulus(1, vals[i]);
            waitDone(1, 40, 1'b1, cyc, bsy);
            e = popExp(1);
            o = observe(1);
            vectors++;
            if (cyc !== 18 || o !== e) begin
                miscompares++;
                $display("[TB] FAIL signed din=%h got %h lat %0d want %h lat 18", vals[i], o, cyc, e);
            end
        end
    endtask

    task automatic test_truncate();
        logic [15:0] vals [3] = '{16'd12345, 16'd9999, 16'd65535};
        int          cyc, bsy;
        exp_t        e, o;
        foreach (vals[i]) begin
            @(negedge clk);
            applyStimulus(2, vals[i]);
            waitDone(2, 40, 1'b1, cyc, bsy);
            e = popExp(2);
            o = observe(2);
            vectors++;
            if (cyc !== 18 || o !== e) begin
                miscompares++;
                $display("[TB] FAIL truncate din=%0d got %h lat %0d want %h lat 18", vals[i], o, cyc, e);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] d;
        int          cyc, bsy;
        exp_t        e, o;
        for (int i = 0; i < 6; i++) begin
            d = 16'($urandom);
            @(negedge clk);
            applyStimulus(0, d);
            waitDone(0, 40, 1'b1, cyc, bsy);
            e = popExp(0);
            o = observe(0);
            vectors++;
            if (cyc !== 18 || o !== e) begin
                miscompares++;
                $display("[TB] FAIL random din=%0d got %h lat %0d want %h lat 18", d, o, cyc, e);
            end
        end
    endtask

    task automatic test_ignore_busy();
        int   cyc, bsy, extra;
        exp_t e, o;
        @(negedge clk);
        applyStimulus(0, 16'd100);
        @(negedge clk);
        dropStart(0);
        repeat (3) @(negedge clk);
        @(negedge clk);
        setIn(0, 1'b1, 16'd200);
        @(negedge clk);
        dropStart(0);
        waitDone(0, 40, 1'b0, cyc, bsy);
        vectors++;
        if (cyc !== 12) begin
            miscompares++;
            $display("[TB] FAIL ignore_latency negedges got %0d want 12", cyc);
        end
        e = popExp(0);
        o = observe(0);
        vectors++;
        if (o !== e) begin
            miscompares++;
            $display("[TB] FAIL ignore_result got %h want %h", o, e);
        end
        extra = 0;
        repeat (25) begin
            @(negedge clk);
            if (getDone(0) || getBusy(0)) extra++;
        end
        vectors++;
        if (extra !== 0) begin
            miscompares++;
            $display("[TB] FAIL ignore_no_second cycles with done/busy got %0d want 0", extra);
        end
    endtask

    task automatic test_reset_abort();
        int   cyc, bsy, extra;
        exp_t e, o;
        @(negedge clk);
        applyStimulus(0, 16'd500);
        @(negedge clk);
        dropStart(0);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({observe(0), getBusy(0), getDone(0)} !== 24'h0) begin
            miscompares++;
            $display("[TB] FAIL abort_clear outputs got %h want 000000",
                     {observe(0), getBusy(0), getDone(0)});
        end
        expU.delete();
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            if (getDone(0)) extra++;
        end
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (getDone(0)) extra++;
        end
        vectors++;
        if (extra !== 0) begin
            miscompares++;
            $display("[TB] FAIL abort_no_done pulses got %0d want 0", extra);
        end
        @(negedge clk);
        applyStimulus(0, 16'd42);
        waitDone(0, 40, 1'b1, cyc, bsy);
        e = popExp(0);
        o = observe(0);
        vectors++;
        if (cyc !== 18 || o !== e) begin
            miscompares++;
            $display("[TB] FAIL abort_recover got %h lat %0d want %h lat 18", o, cyc, e);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_unsigned_max();
        test_back_to_back();
        test_signed();
        test_truncate();
        test_random();
        test_ignore_busy();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Parametrised sequential binary-to-BCD converter for the display path. It is the next generation of the cascaded-counter hex-to-decimal digit chain.
- Uses shift-and-add-3 (double dabble), so latency is fixed at IN_W+1 cycles instead of depending on the input value.
- Adds a start/busy/done handshake, an optional signed-input mode and overflow detection.
- Feeds the seven-segment scan driver, which latches bcd_out on done.

Parameters:
- IN_W, 16, binary input width (2..32).
- DIGITS, 5, number of BCD output digits (1..10). Each digit is 4 bits.
- SIGNED, 0, 1 = din is two's complement; the output is sign plus magnitude.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  conversion request, sampled only in IDLE.
- din  in  IN_W  binary value, captured on the accepted start edge.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse; outputs were updated on this edge.
- bcd_out  out  4*DIGITS  packed BCD, digit 0 in bits [3:0].
- neg  out  1  sign of the last result; always 0 when SIGNED=0.
- overflow  out  1  last result did not fit in DIGITS digits.

Behaviour:
- Reset (async, rst_n=0):
  - busy=0, done=0, bcd_out=0, neg=0, overflow=0.
  - State = IDLE; the internal shift register and counter are cleared.
  - Reset asserted mid-conversion aborts it. No done pulse is produced and the outputs read 0.
- State IDLE:
  - busy=0.
  - On an edge with start=1, capture the magnitude of din into the binary shift register. The magnitude is din itself, or -din when SIGNED=1 and din[IN_W-1]=1.
  - On the same edge: capture the sign, clear the BCD accumulator and the overflow accumulator, load the bit counter with IN_W, go to SHIFT.
- State SHIFT:
  - busy=1.
  - Each cycle, first add 3 to every accumulator digit that is >=5 (combinational).
  - Then shift {accumulator, binary} left by 1.
  - If the bit leaving the MSB of the top digit is 1, set the overflow accumulator.
  - Decrement the counter. When the counter reaches 1 on this edge, go to DONE.
- State DONE:
  - Lasts one cycle; busy=1.
  - On the next edge: bcd_out, neg and overflow take the accumulator values, done=1 for exactly that cycle, busy=0, go to IDLE.
- Latency: start accepted at edge k gives IN_W shift edges (k+1..k+IN_W), then outputs update and done rises at edge k+IN_W+1.
- start is ignored while busy=1; no queueing.
- start held high continuously gives back-to-back conversions. The next start is accepted on the edge after done falls into IDLE, so throughput is one result per IN_W+2 cycles.
- bcd_out, neg and overflow hold their value until the next done. din may change freely after the accepting edge.
- Signed minimum value -2^(IN_W-1) has magnitude 2^(IN_W-1), which is representable in IN_W unsigned bits. neg=1.
- Zero always gives neg=0, including when SIGNED=1.
- Overflow: when overflow=1, bcd_out holds the value modulo 10^DIGITS, which is the truncated low digits.
- Every digit of bcd_out is always a legal BCD value (0..9).

Decomposition:
- Shared package bin2bcd_pkg:
  - state enum {IDLE, SHIFT, DONE};
  - constant BCD_W=4;
  - function min_digits(w) = ceil(w*log10(2)), used in assertions to warn when DIGITS < min_digits(IN_W).
- Sub-module bcd_digit_adj: a 4-bit combinational add-3-if->=5 stage, instantiated DIGITS times by generate.
- The top level holds the FSM, counter and registers.

Test Plan:
- IN_W=16, DIGITS=5, SIGNED=0, din=16'hFFFF, start pulse at edge k -> done at edge k+17, bcd_out=20'h65535, overflow=0, neg=0; busy high for exactly 17 cycles.
- din=0, then din=16'd9 back to back with start held high -> bcd_out=0, then bcd_out=20'h00009. Two done pulses 18 cycles apart.
- SIGNED=1, IN_W=16: din=16'h8000 -> neg=1, bcd_out=20'h32768. din=16'hFFFF -> neg=1, bcd_out=1. din=16'h7FFF -> neg=0, bcd_out=20'h32767.
- DIGITS=4, din=16'd12345 -> overflow=1, bcd_out=16'h2345. A following din=16'd9999 -> overflow=0, bcd_out=16'h9999.
- Start with din=100; pulse start again with din=200 at cycle 5 of the conversion -> the second start is ignored, done once, bcd_out=20'h00100.
- Start with din=500; drop rst_n at cycle 8 -> all outputs 0 immediately, no done. After release, a new start with din=42 -> bcd_out=20'h00042 after 17 cycles.
